// File: rtl/unifiedmem_pkg.sv
// Shared constants and types for the four-bank unified memory and its arbiter.
// Bank depths are informational: addresses are forwarded unmodified and never range-checked.
package unifiedmem_pkg;

    localparam int NUM_BANKS = 4;
    localparam int NUM_REQ   = 2;
    localparam int CNT_W     = 16;

    localparam int unsigned BANK_DEPTH [NUM_BANKS] = '{1024, 32, 1024, 750};

    typedef logic [1:0] bank_t;

endpackage

// File: rtl/bank_rr_arbiter.sv
// Per-bank two-way round-robin arbiter: zero-latency one-hot win; ptr flips away from each winner.
// No backpressure; optional saturating conflict counter under UNIFIEDMEM_ARB_CONFLICT_CNT_EN.
module bank_rr_arbiter
    import unifiedmem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       hit,
    output logic [1:0]       win,
    output logic [CNT_W-1:0] cnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        win = hit;
        if (hit == 2'b11) begin
            win = ptr_q ? 2'b10 : 2'b01;
        end
        // Any grant, contested or not, hands priority to the other requester.
        ptr_d = ptr_q;
        if (win[0]) begin
            ptr_d = 1'b1;
        end else if (win[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef UNIFIEDMEM_ARB_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((hit == 2'b11) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`else
    assign cnt = '0;
`endif

endmodule

// File: rtl/unifiedmem_arbiter.sv
// Two-requester per-bank arbiter for unifiedmem: grants combinational, read data one cycle after grant.
// Losers simply hold req (no queueing); counters enabled by UNIFIEDMEM_ARB_CONFLICT_CNT_EN.
module unifiedmem_arbiter
    import unifiedmem_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int NREQ  = NUM_REQ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*2-1:0]       req_bank,
    input  logic [NREQ*WIDTH-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [NREQ*WIDTH-1:0]   rdata,
    output logic [4*16-1:0]         conflict_cnt,
    output logic [3:0]              mem_we,
    output logic [WIDTH*4-1:0]      mem_a,
    output logic [WIDTH*4-1:0]      mem_wd,
    input  logic [WIDTH*4-1:0]      mem_rd
);

    logic [NUM_BANKS-1:0][1:0]       hit;
    logic [NUM_BANKS-1:0][1:0]       win;
    logic [NUM_BANKS-1:0][CNT_W-1:0] cnt;

    logic [NREQ-1:0]       rvalid_q, rvalid_d;
    logic [NREQ*WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NREQ; i++) begin
                hit[b][i] = req[i] && (bank_t'(req_bank[2*i +: 2]) == bank_t'(b));
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_rr_arbiter u_arb (
            .clk   (clk),
            .reset (reset),
            .hit   (hit[g]),
            .win   (win[g]),
            .cnt   (cnt[g])
        );
        assign conflict_cnt[CNT_W*g +: CNT_W] = cnt[g];
    end

    // Each requester targets one bank, so at most one bank can set its gnt bit.
    always_comb begin
        gnt    = '0;
        mem_we = '0;
        mem_a  = '0;
        mem_wd = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win[b][i]) begin
                    gnt[i]                  = 1'b1;
                    mem_we[b]               = req_we[i];
                    mem_a[WIDTH*b +: WIDTH]  = req_addr[WIDTH*i +: WIDTH];
                    mem_wd[WIDTH*b +: WIDTH] = req_wdata[WIDTH*i +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        rvalid_d = gnt & ~req_we;
        rdata_d  = rdata_q;
        for (int i = 0; i < NREQ; i++) begin
            if (rvalid_d[i]) begin
                rdata_d[WIDTH*i +: WIDTH] = mem_rd[WIDTH*int'(req_bank[2*i +: 2]) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_unifiedmem_arbiter.sv
// Bench for unifiedmem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_unifiedmem_arbiter;
    import unifiedmem_pkg::*;

    localparam int W = 36;
`ifdef UNIFIEDMEM_ARB_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic [1:0]     req       = '0;
    logic [1:0]     req_we    = '0;
    logic [3:0]     req_bank  = '0;
    logic [2*W-1:0] req_addr  = '0;
    logic [2*W-1:0] req_wdata = '0;
    logic [1:0]     gnt, rvalid;
    logic [2*W-1:0] rdata;
    logic [63:0]    conflict_cnt;
    logic [3:0]     mem_we;
    logic [4*W-1:0] mem_a, mem_wd, mem_rd;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         chk_en   = 1'b1;
    logic [1:0] gnt_seen = '0;

    always #5 clk = ~clk;

    unifiedmem_arbiter #(.WIDTH(W), .NREQ(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_bank     (req_bank),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .conflict_cnt (conflict_cnt),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    task automatic check_eq(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] init_val(input int b, input int a);
        if (b == 2 && a == 5) return 36'h1A;
        return {b[1:0], a[9:0], 24'(a * 7919 + b * 101)};
    endfunction

    // Memory stand-in: asynchronous read, write at the clock edge.
    logic [W-1:0] env_mem [4][1024];
    bit env_init = 1'b1;

    always @(posedge clk) begin
        if (env_init) begin
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 1024; a++)
                    env_mem[b][a] <= init_val(b, a);
            env_init <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) env_mem[b][mem_a[W*b +: 10]] <= mem_wd[W*b +: W];
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) mem_rd[W*b +: W] = env_mem[b][mem_a[W*b +: 10]];
    end

    // Reference model: per-bank favoured requester, shadow memory, pending read results.
    logic [W-1:0]   mdl_mem [4][1024];
    bit             m_init   = 1'b0;
    logic [3:0]     m_ptr    = '0;
    logic [1:0]     m_rvalid = '0;
    logic [2*W-1:0] m_rdata  = '0;
    int             m_cnt [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin : model
        logic [1:0]     e_gnt, n_rvalid;
        logic [3:0]     e_we, n_ptr;
        logic [4*W-1:0] e_a, e_wd;
        logic [2*W-1:0] n_rdata;
        logic [63:0]    e_cc;
        int             n_cnt [4];
        int             win, a;
        bit             on0, on1;

        if (!m_init) begin
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < 1024; k++)
                    mdl_mem[b][k] = init_val(b, k);
            m_init = 1'b1;
        end
        if (reset) begin
            m_ptr = '0; m_rvalid = '0; m_rdata = '0;
            for (int b = 0; b < 4; b++) m_cnt[b] = 0;
        end
        e_cc = '0;
        for (int b = 0; b < 4; b++) e_cc[16*b +: 16] = CNT_EN ? 16'(m_cnt[b]) : 16'h0;
        gnt_seen = gnt;
        if (chk_en) begin
            check_eq("rvalid", 144'(rvalid), 144'(m_rvalid));
            check_eq("rdata", 144'(rdata), 144'(m_rdata));
            check_eq("conflict_cnt", 144'(conflict_cnt), 144'(e_cc));
        end

        e_gnt = '0; e_we = '0; e_a = '0; e_wd = '0;
        n_ptr = m_ptr; n_rvalid = '0; n_rdata = m_rdata;
        for (int b = 0; b < 4; b++) begin
            n_cnt[b] = m_cnt[b];
            on0 = req[0] && (int'(req_bank[1:0]) == b);
            on1 = req[1] && (int'(req_bank[3:2]) == b);
            if (on0 && on1) begin
                win = int'(m_ptr[b]);
                if (n_cnt[b] < 65535) n_cnt[b]++;
            end else if (on0) win = 0;
            else if (on1) win = 1;
            else win = -1;
            if (win >= 0) begin
                e_gnt[win]       = 1'b1;
                e_we[b]          = req_we[win];
                e_a[W*b +: W]    = req_addr[W*win +: W];
                e_wd[W*b +: W]   = req_wdata[W*win +: W];
                n_ptr[b]         = (win == 0);
                a                = int'(req_addr[W*win +: 10]);
                if (req_we[win]) mdl_mem[b][a] = req_wdata[W*win +: W];
                else begin
                    n_rvalid[win]         = 1'b1;
                    n_rdata[W*win +: W]   = mdl_mem[b][a];
                end
            end
        end
        if (chk_en) begin
            check_eq("gnt", 144'(gnt), 144'(e_gnt));
            check_eq("mem_we", 144'(mem_we), 144'(e_we));
            check_eq("mem_a", 144'(mem_a), 144'(e_a));
            check_eq("mem_wd", 144'(mem_wd), 144'(e_wd));
        end
        if (!reset) begin
            m_ptr = n_ptr; m_rvalid = n_rvalid; m_rdata = n_rdata;
            for (int b = 0; b < 4; b++) m_cnt[b] = n_cnt[b];
        end
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] we, input logic [3:0] bk,
                         input logic [2*W-1:0] ad, input logic [2*W-1:0] wd);
        @(posedge clk); #1;
        req = r; req_we = we; req_bank = bk; req_addr = ad; req_wdata = wd;
        #2;
    endtask

    task automatic drive_idle();
        drive(2'b00, 2'b00, 4'h0, '0, '0);
    endtask

    initial begin
        int b;
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_rvalid", 144'(rvalid), 144'(2'b00));
        check_eq("rst_rdata", 144'(rdata), 144'(0));
        check_eq("rst_conflict_cnt", 144'(conflict_cnt), 144'(0));
        @(posedge clk); #1 reset = 1'b0;

        // Lone read of bank 2 address 5.
        drive(2'b01, 2'b00, {2'd0, 2'd2}, {36'd0, 36'd5}, '0);
        check_eq("lone_gnt", 144'(gnt), 144'(2'b01));
        check_eq("lone_we", 144'(mem_we), 144'(4'b0000));
        check_eq("lone_addr", 144'(mem_a[W*2 +: W]), 144'(36'd5));
        drive_idle();
        check_eq("lone_rvalid", 144'(rvalid), 144'(2'b01));
        check_eq("lone_rdata", 144'(rdata[W-1:0]), 144'(36'h1A));

        // Different banks in parallel: R0 writes bank 0, R1 reads bank 3.
        drive(2'b11, 2'b01, {2'd3, 2'd0}, {36'd749, 36'd3}, {36'd0, 36'hABCDEF});
        check_eq("par_gnt", 144'(gnt), 144'(2'b11));
        check_eq("par_we", 144'(mem_we), 144'(4'b0001));
        drive_idle();
        check_eq("par_rvalid", 144'(rvalid), 144'(2'b10));
        check_eq("par_rdata1", 144'(rdata[2*W-1:W]), 144'(init_val(3, 749)));

        // Same-bank conflict on untouched bank 1: grants alternate starting with R0.
        drive(2'b11, 2'b00, {2'd1, 2'd1}, {36'd2, 36'd1}, '0);
        check_eq("cfl_gnt0", 144'(gnt), 144'(2'b01));
        drive(2'b11, 2'b00, {2'd1, 2'd1}, {36'd2, 36'd3}, '0);
        check_eq("cfl_gnt1", 144'(gnt), 144'(2'b10));
        drive(2'b11, 2'b00, {2'd1, 2'd1}, {36'd4, 36'd3}, '0);
        check_eq("cfl_gnt2", 144'(gnt), 144'(2'b01));
        check_eq("cfl_cnt_bank1", 144'(conflict_cnt[31:16]), 144'(CNT_EN ? 16'd2 : 16'd0));
        drive_idle();

        // Read-after-write on bank 1 by R1.
        drive(2'b10, 2'b10, {2'd1, 2'd0}, {36'd31, 36'd0}, {36'h123456789, 36'd0});
        check_eq("raw_wgnt", 144'(gnt), 144'(2'b10));
        check_eq("raw_we", 144'(mem_we), 144'(4'b0010));
        drive(2'b10, 2'b00, {2'd1, 2'd0}, {36'd31, 36'd0}, '0);
        check_eq("raw_rgnt", 144'(gnt), 144'(2'b10));
        drive_idle();
        check_eq("raw_rvalid", 144'(rvalid), 144'(2'b10));
        check_eq("raw_rdata1", 144'(rdata[2*W-1:W]), 144'(36'h123456789));

        // Reset in the cycle after a read grant; bank 0 ptr favours R1 beforehand.
        drive(2'b01, 2'b00, {2'd0, 2'd0}, {36'd0, 36'd3}, '0);
        check_eq("rmr_gnt", 144'(gnt), 144'(2'b01));
        @(posedge clk); #1;
        req = 2'b00; reset = 1'b1;
        #2;
        check_eq("rmr_rvalid", 144'(rvalid), 144'(2'b00));
        check_eq("rmr_rdata", 144'(rdata), 144'(0));
        @(posedge clk); #1 reset = 1'b0;
        drive(2'b11, 2'b00, {2'd0, 2'd0}, {36'd9, 36'd8}, '0);
        check_eq("rmr_ptr_gnt", 144'(gnt), 144'(2'b01));
        drive(2'b10, 2'b00, {2'd0, 2'd0}, {36'd9, 36'd8}, '0);
        check_eq("rmr_r1_gnt", 144'(gnt), 144'(2'b10));
        drive_idle();

        // Random traffic: each requester holds its request until granted.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (req[i] && gnt_seen[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) != 0) begin
                    b = $urandom_range(0, 3);
                    req[i]              = 1'b1;
                    req_we[i]           = 1'($urandom_range(0, 1));
                    req_bank[2*i +: 2]  = 2'(b);
                    req_addr[W*i +: W]  = ($urandom_range(0, 1) != 0) ? 36'($urandom_range(0, 7))
                                          : 36'($urandom_range(0, BANK_DEPTH[b] - 1));
                    req_wdata[W*i +: W] = 36'({$urandom(), $urandom()});
                end
            end
        end
        drive_idle();
        drive_idle();

        // Sustained bank-0 conflicts to push the counter into saturation.
        chk_en = 1'b0;
        @(posedge clk); #1;
        req = 2'b11; req_we = 2'b00; req_bank = 4'h0; req_addr = {36'd1, 36'd2};
        repeat (65540) @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        chk_en = 1'b1;
        check_eq("sat_cnt_bank0", 144'(conflict_cnt[15:0]), 144'(CNT_EN ? 16'hFFFF : 16'h0));
        repeat (3) @(posedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unifiedmem_arbiter.md
# unifiedmem_arbiter

Two-requester, per-bank arbiter placed in front of the four-bank `unifiedmem` memory. It shares the memory between the pipeline (requester 0) and the loader/debug port (requester 1). Requests to different banks are granted in the same cycle. Requests to the same bank are resolved round-robin per bank. The block drives the memory's packed `we`/`a`/`wd` lanes and returns registered read data with a valid strobe.

## Interface
- `WIDTH`, 36: bank address/data lane width; must match `unifiedmem`.
- `NREQ`, 2: number of requesters; the design is fixed at 2 and the parameter exists only for packing.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  [NREQ-1:0]  request valid, one bit per requester.
- `req_we`  in  [NREQ-1:0]  1 = write, 0 = read.
- `req_bank`  in  [NREQ*2-1:0]  target bank 0..3 per requester.
- `req_addr`  in  [NREQ*WIDTH-1:0]  word address within the bank.
- `req_wdata`  in  [NREQ*WIDTH-1:0]  write data.
- `gnt`  out  [NREQ-1:0]  combinational grant; the request is accepted this cycle.
- `rvalid`  out  [NREQ-1:0]  read data valid, one cycle after a read grant.
- `rdata`  out  [NREQ*WIDTH-1:0]  registered read data.
- `conflict_cnt`  out  [4*16-1:0]  per-bank conflict counters (see Configuration).
- `mem_we`  out  4  to `unifiedmem.we`.
- `mem_a`  out  [WIDTH*4-1:0]  to `unifiedmem.a`.
- `mem_wd`  out  [WIDTH*4-1:0]  to `unifiedmem.wd`.
- `mem_rd`  in  [WIDTH*4-1:0]  from `unifiedmem.rd`.

## Operation
- **Request rule:** a requester holds `req` and all `req_*` fields stable until the cycle `gnt` is seen. It may issue a new request in the following cycle.
- **Per-bank priority pointer** `ptr[b]` (1 bit): the requester named by `ptr[b]` wins a same-bank conflict.
- **No contention:** a lone requester on a bank is always granted.
- **Pointer update:** on any grant to requester i on bank b, `ptr[b] <= ~i` at the clock edge. Uncontested grants also update the pointer.
- **Granted bank b:** `mem_a` lane b = granted `req_addr`. `mem_wd` lane b = granted `req_wdata`. `mem_we[b]` = granted `req_we`.
- **Non-granted lanes:** `mem_a` = 0, `mem_wd` = 0, `mem_we` = 0.
- **Read capture:** a read grant captures `mem_rd` lane b into that requester's `rdata` slice at the edge. `rvalid[i]` is high for exactly the next cycle.
- **Held `rdata`:** `rdata` holds its value until the next read grant for that requester.
- **Write grant:** produces no `rvalid`.
- **Address checking:** addresses are passed unmodified. Out-of-range addresses for the bank depths (1024/32/1024/750) are a requester error and are not checked.
- **Same requester:** issues at most one request per cycle.

## Timing
- Grant latency is 0 cycles (combinational from `req`, `req_bank`, `ptr`).
- A write commits at the rising edge ending the grant cycle.
- Read latency is 1 cycle from grant to `rvalid`.
- **Read-after-write, same bank:** a read granted in the cycle after a write grant returns the new data.
- **Simultaneous write and read, same bank:** only one is granted, so no read/write race exists inside a bank.
- **Back-to-back conflicts on one bank:** grants alternate 0,1,0,1. Neither requester waits more than 1 cycle.
- **Reset values:**
  - `ptr` = 0 (requester 0 favoured)
  - `rvalid` = 0, `rdata` = 0
  - `conflict_cnt` = 0
  - `gnt`/`mem_*` follow their inputs combinationally
- **Reset asserted mid-operation:** a pending `rvalid` is dropped. The requester must reissue.

## Configuration
- **`UNIFIEDMEM_ARB_CONFLICT_CNT_EN` defined:**
  - Each bank has a 16-bit counter that increments once per cycle in which both requesters target that bank with `req` high.
  - The counter saturates at 16'hFFFF and is cleared only by reset.
  - Bank b occupies `conflict_cnt[16*b+15:16*b]`.
- **Not defined:** `conflict_cnt` is tied to 0 and no counter flops are synthesized.

## Structure
- **Package `unifiedmem_pkg`:**
  - `NUM_BANKS` = 4
  - `NUM_REQ` = 2
  - bank depth constants `BANK_DEPTH[0..3]` = 1024/32/1024/750
  - `typedef logic [1:0] bank_t`
- **Sub-module `bank_rr_arbiter`:**
  - Instantiated once per bank.
  - Inputs: two per-bank hit bits.
  - Outputs: one-hot win.
  - Holds `ptr` and the optional conflict counter.
- **Top level:** holds request decode, lane muxing and the read-return registers.

## Test plan
- **Lone read:** R0 reads bank 2 addr 5, memory holds 5'h1A → `gnt`=01 same cycle, `mem_we`=0000, `rvalid[0]`=1 next cycle, `rdata0`=0x1A.
- **Parallel, different banks:** R0 writes bank 0 addr 3 data 24'hABCDEF, R1 reads bank 3 addr 749 → both granted, `mem_we`=0001, R1 `rvalid` next cycle.
- **Same-bank conflict after reset:** both request bank 1 → cycle 0 `gnt`=01, cycle 1 `gnt`=10, cycle 2 `gnt`=01; `conflict_cnt` bank 1 = 2 after cycle 1 (macro on).
- **Read-after-write:** R1 writes bank 1 addr 31 = 36'h123456789, next cycle R1 reads it → `rdata1`=36'h123456789.
- **Reset mid-read:** `reset` asserted in the cycle after a read grant → `rvalid`=0, `rdata`=0, `ptr` back to 0.
- **Counter saturation:** 65540 continuous bank-0 conflicts → `conflict_cnt` bank 0 = 16'hFFFF (macro on); stays 0 with macro off.
